// File: rtl/fp_result_check.sv
// fp_result_check: checking stage behind fp_unit.
// Expected results are queued as operations issue. Each res_valid pulse pops
// one entry and compares it with the calculated result and flags. The stage
// keeps saturating pass/fail counts, latches the first mismatch, and flags
// completion once the entry marked last has been consumed.
// Optional build macro: FP_CHECK_NAN_CANON_EN. When it is defined, a canonical
// quiet NaN from fp_unit is accepted against any reference NaN payload, except
// for fcvt_f2i and fcmp ops. Flags are always compared exactly.
module fp_result_check #(
  parameter int DEPTH = 8,
  parameter int CNTW  = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            exp_valid,
  output logic            exp_ready,
  input  logic [63:0]     exp_result,
  input  logic [4:0]      exp_flags,
  input  logic [1:0]      exp_fmt,
  input  logic [9:0]      exp_opcode,
  input  logic            exp_last,
  input  logic            res_valid,
  input  logic [63:0]     res_result,
  input  logic [4:0]      res_flags,
  output logic [CNTW-1:0] pass_count,
  output logic [CNTW-1:0] fail_count,
  output logic            error,
  output logic            underflow,
  output logic            done,
  output logic [63:0]     first_diff,
  output logic [4:0]      first_fdiff,
  output logic [63:0]     first_exp
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 82;  // last + opcode + fmt + flags + result

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;

  logic          push;
  logic          pop;
  logic          underflow_evt;
  logic [EW-1:0] head;
  logic [63:0]   head_result;
  logic [4:0]    head_flags;
  logic [1:0]    head_fmt;
  logic [9:0]    head_opcode;
  logic          head_last;
  logic [63:0]   diff;
  logic [4:0]    fdiff;
  logic          mismatch;
  logic          unused_fields;

  logic [CNTW-1:0] cnt_reg [2];
  logic [1:0]      cnt_inc;

  logic        error_reg;
  logic        underflow_reg;
  logic        done_reg;
  logic [63:0] first_diff_reg;
  logic [4:0]  first_fdiff_reg;
  logic [63:0] first_exp_reg;

  assign exp_ready     = (count_reg != CW'(DEPTH));
  assign push          = exp_valid & exp_ready;
  assign pop           = res_valid & (count_reg != '0);
  assign underflow_evt = res_valid & (count_reg == '0);

  // Head of queue is read combinationally so the compare lands in the pulse cycle.
  assign head        = mem[rd_ptr_reg];
  assign head_result = head[63:0];
  assign head_flags  = head[68:64];
  assign head_fmt    = head[70:69];
  assign head_opcode = head[80:71];
  assign head_last   = head[81];

  // fmt and most opcode bits only matter to the NaN relaxation.
  assign unused_fields = ^{head_fmt, head_opcode};

  // Entry storage: written on accepted push, no reset needed on the data itself.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr_reg] <= {exp_last, exp_opcode, exp_fmt, exp_flags, exp_result};
    end
  end

  // Occupancy: simultaneous push and pop leave the count unchanged.
  always_comb begin
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + CW'(1);
    end else if (pop && !push) begin
      count_next = count_reg - CW'(1);
    end
  end

  // Queue pointers and count; pointers wrap naturally at DEPTH.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
    end
  end

  // Result difference; a canonical NaN only has its class bits compared when relaxed.
  always_comb begin
    diff = res_result ^ head_result;
`ifdef FP_CHECK_NAN_CANON_EN
    if (!head_opcode[9] && !head_opcode[6]) begin
      if (head_fmt == 2'd0) begin
        if (res_result[31:0] == 32'h7FC0_0000) begin
          diff = {32'h0, 1'b0, res_result[30:22] ^ head_result[30:22], 22'h0};
        end
      end else if (res_result == 64'h7FF8_0000_0000_0000) begin
        diff = {1'b0, res_result[62:51] ^ head_result[62:51], 51'h0};
      end
    end
`endif
  end

  assign fdiff    = res_flags ^ head_flags;
  assign mismatch = (diff != '0) | (fdiff != '0);

  assign cnt_inc[0] = pop & ~mismatch;
  assign cnt_inc[1] = pop &  mismatch;

  // Pass (index 0) and fail (index 1) counters, saturating at all-ones.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          cnt_reg[gi] <= '0;
        end else if (cnt_inc[gi] && (cnt_reg[gi] != {CNTW{1'b1}})) begin
          cnt_reg[gi] <= cnt_reg[gi] + CNTW'(1);
        end
      end
    end
  endgenerate

  // Sticky status and first-mismatch capture (frozen once error is set).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      error_reg       <= 1'b0;
      underflow_reg   <= 1'b0;
      done_reg        <= 1'b0;
      first_diff_reg  <= '0;
      first_fdiff_reg <= '0;
      first_exp_reg   <= '0;
    end else begin
      if (pop && mismatch && !error_reg) begin
        first_diff_reg  <= diff;
        first_fdiff_reg <= fdiff;
        first_exp_reg   <= head_result;
      end
      if (underflow_evt || (pop && mismatch)) error_reg <= 1'b1;
      if (underflow_evt)                      underflow_reg <= 1'b1;
      if (pop && head_last)                   done_reg <= 1'b1;
    end
  end

  assign pass_count  = cnt_reg[0];
  assign fail_count  = cnt_reg[1];
  assign error       = error_reg;
  assign underflow   = underflow_reg;
  assign done        = done_reg;
  assign first_diff  = first_diff_reg;
  assign first_fdiff = first_fdiff_reg;
  assign first_exp   = first_exp_reg;

endmodule
